// File: rtl/alu_seq_ctrl.sv
// Sequencer that steps an external single-cycle ALU through NEG/EXEC/FLAG passes per request.
// Define ALU_SEQ_B2B_EN to allow a new request to be accepted during the result handoff cycle.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_result,
    input  logic        alu_sign,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_sign,
    output logic        res_carry,
    output logic        res_zero
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StNeg  = 3'd1;
    localparam logic [2:0] StExec = 3'd2;
    localparam logic [2:0] StFlag = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpXor = 3'd3;
    localparam logic [2:0] OpSll = 3'd4;
    localparam logic [2:0] OpSrl = 3'd5;
    localparam logic [2:0] OpSra = 3'd6;
    localparam logic [2:0] OpNeg = 3'd7;

    localparam logic [3:0] SelAdd   = 4'd0;
    localparam logic [3:0] SelTwos  = 4'd1;
    localparam logic [3:0] SelAnd   = 4'd2;
    localparam logic [3:0] SelXor   = 4'd3;
    localparam logic [3:0] SelSll   = 4'd4;
    localparam logic [3:0] SelSrl   = 4'd5;
    localparam logic [3:0] SelSra   = 4'd6;

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        sign_q, sign_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic [3:0]  exec_sel;
    logic        accept;

`ifdef ALU_SEQ_B2B_EN
    assign op_ready = (state_q == StIdle) || ((state_q == StDone) && res_ready);
`else
    assign op_ready = (state_q == StIdle);
`endif

    assign accept    = op_valid && op_ready;
    assign res_valid = (state_q == StDone);
    assign res_data  = result_q;
    assign res_sign  = sign_q;
    assign res_carry = carry_q;
    assign res_zero  = zero_q;

    // SUB has already had B negated in the NEG pass, so it executes as a plain add.
    always_comb begin
        exec_sel = SelAdd;
        case (op_q)
            OpAdd:   exec_sel = SelAdd;
            OpSub:   exec_sel = SelAdd;
            OpAnd:   exec_sel = SelAnd;
            OpXor:   exec_sel = SelXor;
            OpSll:   exec_sel = SelSll;
            OpSrl:   exec_sel = SelSrl;
            OpSra:   exec_sel = SelSra;
            OpNeg:   exec_sel = SelTwos;
            default: exec_sel = SelAdd;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        sign_d   = sign_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_sel  = SelAdd;

        if (accept) begin
            op_d = op_code;
            a_d  = op_a;
            b_d  = op_b;
        end

        case (state_q)
            StIdle: begin
                if (accept) state_d = (op_code == OpSub) ? StNeg : StExec;
            end
            StNeg: begin
                alu_sel = SelTwos;
                alu_b   = b_q;
                b_d     = alu_result;
                state_d = StExec;
            end
            StExec: begin
                alu_a    = a_q;
                alu_b    = b_q;
                alu_sel  = exec_sel;
                result_d = alu_result;
                state_d  = StFlag;
            end
            StFlag: begin
                // The ALU registers carry from the EXEC add, so it is valid in this cycle.
                alu_a   = result_q;
                sign_d  = alu_sign;
                zero_d  = alu_zero;
                carry_d = ((op_q == OpAdd) || (op_q == OpSub)) ? alu_carry : 1'b0;
                state_d = StDone;
            end
            StDone: begin
                if (res_ready) begin
                    if (accept) state_d = (op_code == OpSub) ? StNeg : StExec;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL: op_valid  input  1  request valid; op_ready  output  1  controller can accept a request.
REQ-004 SHALL: op_code  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 SRA, 7 NEG (-B).
REQ-005 SHALL: op_a  input  32  operand A; op_b  input  32  operand B / shift amount.
REQ-006 SHALL: alu_a  output  32, alu_b  output  32, alu_sel  output  4  drive the ALU; Sel codes 0 ADD, 1 TWOSCOMP, 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 SRA.
REQ-007 SHALL: alu_result  input  32, alu_sign  input  1, alu_zero  input  1  combinational ALU outputs (sign/zero describe alu_a); alu_carry  input  1  ALU carry, registered by the ALU one clock after the add pass.
REQ-008 SHALL: res_valid  output  1, res_ready  input  1  result handshake; res_data  output  32; res_sign, res_carry, res_zero  output  1 each.

Function
REQ-009 SHALL: FSM states IDLE, NEG, EXEC, FLAG, DONE.
REQ-010 SHALL: op_ready = 1 only in IDLE; op_valid&&op_ready captures op_code, op_a, op_b; next state NEG if SUB, else EXEC.
REQ-011 SHALL: NEG: alu_sel=1, alu_b=captured B, alu_a=0; alu_result written back over captured B; next EXEC.
REQ-012 SHALL: EXEC: alu_a=captured A, alu_b=captured B, alu_sel per op (SUB->0, NEG->1, others per REQ-006); alu_result captured into result register; next FLAG.
REQ-013 SHALL: FLAG: alu_a=result register, alu_b=0, alu_sel=0; capture alu_sign, alu_zero; capture alu_carry for ADD/SUB, force 0 for all other ops; next DONE.
REQ-014 SHALL: DONE: res_valid=1; res_data/flags held stable until res_ready=1; then IDLE.
REQ-015 SHALL: latency accept edge -> res_valid high = 3 cycles (SUB: 4 cycles); res_valid never asserts in any other state.
REQ-016 SHALL: alu_a, alu_b, alu_sel = 0 in IDLE and DONE.
REQ-017 SHALL: shift amount passed unmodified in op_b; arithmetic modulo 2^32; SUB carry = carry-out of A + (~B+1).
REQ-018 SHALL: op_valid while not ready ignored; inputs sampled only at accept edge.

Reset
REQ-019 SHALL: rst_n low at a rising edge -> IDLE next cycle, any in-flight op discarded, regardless of state.
REQ-020 SHALL: reset values: op_ready 1 (after reset edge), res_valid 0, res_data 0, res_sign 0, res_carry 0, res_zero 0, alu_a/alu_b/alu_sel 0.

Configuration
REQ-021 SHALL: macro ALU_SEQ_B2B_EN defined -> op_ready also 1 in DONE when res_ready=1; accept in same cycle as result handoff, go straight to NEG/EXEC (ADD-to-ADD throughput 1 result per 3 cycles).
REQ-022 SHALL: ALU_SEQ_B2B_EN undefined -> DONE always returns to IDLE; op_ready 0 in DONE; throughput 1 result per 4 cycles (ADD).

Verification
REQ-023 SHALL: ADD A=0xFFFFFFFF B=0x00000001 -> res_data 0x00000000, zero 1, carry 1, sign 0, res_valid 3 cycles after accept.
REQ-024 SHALL: SUB A=5 B=7 -> alu_sel sequence 1,0,0; res_data 0xFFFFFFFE, sign 1, zero 0, carry 0; res_valid 4 cycles after accept.
REQ-025 SHALL: SRA A=0x80000000 B=4 -> res_data 0xF8000000, sign 1, carry 0; XOR A=B=0x1234 -> res_data 0, zero 1.
REQ-026 SHALL: res_ready held 0 for 5 cycles in DONE -> res_data/flags unchanged, op_ready 0, op_valid pulses ignored.
REQ-027 SHALL: rst_n low during FLAG -> next cycle res_valid 0, state IDLE, all outputs at reset values.
REQ-028 SHALL: with ALU_SEQ_B2B_EN, two back-to-back ADDs (1+2, 3+4) -> results 3 and 7, second res_valid exactly 3 cycles after first handoff edge.
